// File: rtl/pe3x3_row_sched_if.sv
// Scheduler-side bundle for pe3x3_row_sched: start/config, fmap/weight read strobe,
// PE results in, accumulated row out. sat_flag_o exists only with PE3X3_ROW_SCHED_SAT_EN.
interface pe3x3_row_sched_if #(
  parameter int IW         = 24,
  parameter int FW         = 8,
  parameter int OUTPUT_NUM = 9,
  parameter int ROW_W      = 8
);
  localparam int DW = OUTPUT_NUM * (IW + FW);

  logic             start_i;
  logic [ROW_W-1:0] num_rows_i;
  logic             united_i;
  logic             fmap_req_o;
  logic [ROW_W+1:0] fmap_row_o;
  logic [1:0]       krow_o;
  logic             pe_config_o;
  logic [DW-1:0]    pe_res_i;
  logic [DW-1:0]    acc_o;
  logic             acc_valid_o;
  logic             acc_ready_i;
  logic [ROW_W-1:0] out_row_o;
  logic             busy_o;
  logic             done_o;
`ifdef PE3X3_ROW_SCHED_SAT_EN
  logic             sat_flag_o;

  modport slave (
    input  start_i, num_rows_i, united_i, pe_res_i, acc_ready_i,
    output fmap_req_o, fmap_row_o, krow_o, pe_config_o, acc_o, acc_valid_o,
           out_row_o, busy_o, done_o, sat_flag_o
  );
  modport master (
    output start_i, num_rows_i, united_i, pe_res_i, acc_ready_i,
    input  fmap_req_o, fmap_row_o, krow_o, pe_config_o, acc_o, acc_valid_o,
           out_row_o, busy_o, done_o, sat_flag_o
  );
`else
  modport slave (
    input  start_i, num_rows_i, united_i, pe_res_i, acc_ready_i,
    output fmap_req_o, fmap_row_o, krow_o, pe_config_o, acc_o, acc_valid_o,
           out_row_o, busy_o, done_o
  );
  modport master (
    output start_i, num_rows_i, united_i, pe_res_i, acc_ready_i,
    input  fmap_req_o, fmap_row_o, krow_o, pe_config_o, acc_o, acc_valid_o,
           out_row_o, busy_o, done_o
  );
`endif
endinterface

// File: rtl/pe3x3_row_sched.sv
// 3x3 PE stripe row scheduler: issues 3 kernel rows per output row, accumulates the
// PE lanes and hands each finished row to writeback. PE3X3_ROW_SCHED_SAT_EN selects saturation.
module pe3x3_row_sched #(
  parameter int IW         = 24,
  parameter int FW         = 8,
  parameter int OUTPUT_NUM = 9,
  parameter int ROW_W      = 8,
  parameter int PE_LAT     = 1
) (
  input logic               clk,
  input logic               rst,
  pe3x3_row_sched_if.slave  bus
);
  localparam int LW = IW + FW;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, OUT, FIN} state_t;
  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } tag_t;

  state_t                         r_state, w_next;
  logic [1:0]                     r_krow;
  logic [ROW_W-1:0]               r_out_row, r_num_rows;
  logic                           r_united;
  logic [OUTPUT_NUM-1:0][LW-1:0]  r_acc, w_acc_nxt;
  logic                           r_acc_valid;
  tag_t                           r_tag_pipe [PE_LAT:1];
  tag_t                           w_tag_in, w_tag_out;
  logic                           w_issue, w_accept, w_last_row, w_start;

  assign w_issue    = (r_state == ISSUE);
  assign w_start    = (r_state == IDLE) && bus.start_i;
  assign w_accept   = r_acc_valid && bus.acc_ready_i;
  assign w_last_row = (r_out_row == r_num_rows - ROW_W'(1));
  assign w_tag_in   = '{vld: w_issue, first: w_issue && (r_krow == 2'd0),
                        last: w_issue && (r_krow == 2'd2)};
  assign w_tag_out  = r_tag_pipe[PE_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start_i) w_next = (bus.num_rows_i == '0) ? FIN : ISSUE;
      ISSUE:   if (r_krow == 2'd2) w_next = DRAIN;
      DRAIN:   if (w_tag_out.vld && w_tag_out.last) w_next = OUT;
      OUT:     if (w_accept) w_next = w_last_row ? FIN : ISSUE;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_krow      <= '0;
      r_out_row   <= '0;
      r_num_rows  <= '0;
      r_united    <= 1'b0;
      r_acc_valid <= 1'b0;
    end else begin
      // A zero-row start only pulses done; mode and row state are left alone.
      if (w_start && bus.num_rows_i != '0) begin
        r_num_rows <= bus.num_rows_i;
        r_united   <= bus.united_i;
        r_out_row  <= '0;
        r_krow     <= '0;
      end
      if (w_issue) r_krow <= (r_krow == 2'd2) ? 2'd0 : r_krow + 2'd1;
      if (r_state == DRAIN && w_next == OUT) r_acc_valid <= 1'b1;
      else if (w_accept)                     r_acc_valid <= 1'b0;
      if (w_accept && !w_last_row) r_out_row <= r_out_row + ROW_W'(1);
    end
  end

  // Tags travel alongside the PE pipeline so results are matched to their kernel row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= PE_LAT; i++) r_tag_pipe[i] <= '0;
    end else begin
      r_tag_pipe[1] <= w_tag_in;
      for (int i = 2; i <= PE_LAT; i++) r_tag_pipe[i] <= r_tag_pipe[i-1];
    end
  end

`ifdef PE3X3_ROW_SCHED_SAT_EN
  logic [OUTPUT_NUM-1:0] w_ovf;
  logic                  r_sat_flag;
`endif

  for (genvar k = 0; k < OUTPUT_NUM; k++) begin : g_lane
    logic [LW-1:0] w_res, w_sum;
    assign w_res = bus.pe_res_i[k*LW +: LW];
    assign w_sum = r_acc[k] + w_res;
`ifdef PE3X3_ROW_SCHED_SAT_EN
    // Same-sign operands producing an opposite-sign result means overflow.
    assign w_ovf[k] = !w_tag_out.first && (r_acc[k][LW-1] == w_res[LW-1]) &&
                      (w_sum[LW-1] != r_acc[k][LW-1]);
    assign w_acc_nxt[k] = w_tag_out.first ? w_res :
                          !w_ovf[k]       ? w_sum :
                          r_acc[k][LW-1]  ? {1'b1, {(LW-1){1'b0}}} : {1'b0, {(LW-1){1'b1}}};
`else
    assign w_acc_nxt[k] = w_tag_out.first ? w_res : w_sum;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_acc <= '0;
    else if (w_tag_out.vld) r_acc <= w_acc_nxt;
  end

`ifdef PE3X3_ROW_SCHED_SAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              r_sat_flag <= 1'b0;
    else if (w_start)                     r_sat_flag <= 1'b0;
    else if (w_tag_out.vld && (|w_ovf))   r_sat_flag <= 1'b1;
  end
  assign bus.sat_flag_o = r_sat_flag;
`endif

  assign bus.fmap_req_o  = w_issue;
  assign bus.krow_o      = r_krow;
  assign bus.fmap_row_o  = (ROW_W+2)'(r_out_row) + (ROW_W+2)'(r_krow);
  assign bus.pe_config_o = r_united;
  assign bus.acc_o       = r_acc;
  assign bus.acc_valid_o = r_acc_valid;
  assign bus.out_row_o   = r_out_row;
  assign bus.busy_o      = (r_state != IDLE);
  assign bus.done_o      = (r_state == FIN);
endmodule
